// File: rtl/mcdt_pkg.sv
// Shared constants and types for the MCDT link: channel count, id encoding
// and margin width used by the receive demultiplexer.
package mcdt_pkg;
   localparam int NUM_CH   = 3;
   localparam int ID_W     = 2;
   localparam int MARGIN_W = 6;

   typedef logic [ID_W-1:0] ch_id_t;

   localparam ch_id_t ID_ILLEGAL = 2'd3;
endpackage

// File: rtl/mcdt_rx_fifo.sv
// Per-channel synchronous FIFO with a registered head word, so data_o is
// reset to zero and holds its last value while the FIFO is empty.
module mcdt_rx_fifo
   import mcdt_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int DW    = 32,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic                push_i,
   input  logic                pop_i,
   input  logic [DW-1:0]       data_i,
   output logic [DW-1:0]       data_o,
   output logic [CW-1:0]       count_o,
   output logic                full_o,
   output logic                empty_o,
   output logic [MARGIN_W-1:0] margin_o
);
   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [DW-1:0] data_q, data_d;
   logic          do_push, do_pop;

   assign empty_o  = (count_q == '0);
   assign full_o   = (count_q == CW'(DEPTH));
   assign do_pop   = pop_i && !empty_o;
   assign do_push  = push_i && (!full_o || do_pop);
   assign count_o  = count_q;
   assign data_o   = data_q;
   assign margin_o = MARGIN_W'(DEPTH) - MARGIN_W'(count_q);

   always_comb begin
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
      data_d   = data_q;
      // A push lands at the new head only when nothing older remains.
      if (do_push && (count_q == CW'(do_pop)))
         data_d = data_i;
      else if (count_d != '0)
         data_d = mem_q[rd_ptr_d];
   end

   always_ff @(posedge clk_i) begin
      if (rstn_i && do_push)
         mem_q[wr_ptr_q] <= data_i;
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         data_q   <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         data_q   <= data_d;
      end
   end
endmodule

// File: rtl/mcdt_rx.sv
// MCDT receiver: demultiplexes the merged stream by id into three FIFOs,
// counting overflow and illegal-id words as drops.
module mcdt_rx
   import mcdt_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int DW    = 32
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic [DW-1:0]       mcdt_data_i,
   input  logic                mcdt_val_i,
   input  logic [ID_W-1:0]     mcdt_id_i,
   output logic [DW-1:0]       ch0_data_o,
   output logic                ch0_valid_o,
   input  logic                ch0_ready_i,
   output logic [MARGIN_W-1:0] ch0_margin_o,
   output logic [DW-1:0]       ch1_data_o,
   output logic                ch1_valid_o,
   input  logic                ch1_ready_i,
   output logic [MARGIN_W-1:0] ch1_margin_o,
   output logic [DW-1:0]       ch2_data_o,
   output logic                ch2_valid_o,
   input  logic                ch2_ready_i,
   output logic [MARGIN_W-1:0] ch2_margin_o,
   output logic [15:0]         drop_cnt_o,
   output logic                err_id_o
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [NUM_CH-1:0]                rdy, vld, full, empty, hit, pop, push;
   logic [NUM_CH-1:0][DW-1:0]        dout;
   logic [NUM_CH-1:0][CW-1:0]        cnt;
   logic [NUM_CH-1:0][MARGIN_W-1:0]  margin;
   logic [15:0]                      drop_q, drop_d;
   logic                             err_q, err_d, bad_id, drop;

   assign rdy = {ch2_ready_i, ch1_ready_i, ch0_ready_i};

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign hit[g]  = mcdt_val_i && (mcdt_id_i == ch_id_t'(g));
      assign pop[g]  = rdy[g] && !empty[g];
      // Full FIFO still accepts when its head leaves in the same cycle.
      assign push[g] = hit[g] && (!full[g] || pop[g]);
      assign vld[g]  = (cnt[g] != '0);

      mcdt_rx_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
         .clk_i    (clk_i),
         .rstn_i   (rstn_i),
         .push_i   (push[g]),
         .pop_i    (pop[g]),
         .data_i   (mcdt_data_i),
         .data_o   (dout[g]),
         .count_o  (cnt[g]),
         .full_o   (full[g]),
         .empty_o  (empty[g]),
         .margin_o (margin[g])
      );
   end

   assign bad_id = mcdt_val_i && (mcdt_id_i == ID_ILLEGAL);
   assign drop   = bad_id || |(hit & ~push);

   always_comb begin
      drop_d = drop_q;
      if (drop && (drop_q != 16'hFFFF))
         drop_d = drop_q + 16'd1;
      err_d = err_q || bad_id;
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         drop_q <= '0;
         err_q  <= 1'b0;
      end else begin
         drop_q <= drop_d;
         err_q  <= err_d;
      end
   end

   assign ch0_data_o   = dout[0];
   assign ch1_data_o   = dout[1];
   assign ch2_data_o   = dout[2];
   assign ch0_valid_o  = vld[0];
   assign ch1_valid_o  = vld[1];
   assign ch2_valid_o  = vld[2];
   assign ch0_margin_o = margin[0];
   assign ch1_margin_o = margin[1];
   assign ch2_margin_o = margin[2];
   assign drop_cnt_o   = drop_q;
   assign err_id_o     = err_q;
endmodule
